t_toggle_arbiter: RTL and testbench
===================================

// Module: t_toggle_arbiter
// PURPOSE
//   Shares one T-type toggle flip-flop among NREQ requesters. A round-robin
//   arbiter grants a single requester at a time. Each grant issues exactly one
//   toggle of the shared state q, then holds ownership for HOLD cycles.
//   The block sits between the request sources and the T storage element.
//   It owns the T storage element (q), the grant bus and a toggle counter.
// PARAMETERS
//   NREQ  4  number of requesters, >= 2
//   HOLD  2  cycles gnt stays asserted per grant, >= 1
//   CW    8  width of toggle counter tog_cnt
// PORTS
//   clk      in   1     rising-edge clock
//   rst      in   1     asynchronous, active-low reset
//   clr      in   1     synchronous clear of q/tog_cnt, aborts current grant
//   req      in   NREQ  request vector, level-sensitive, bit i = requester i
//   gnt      out  NREQ  one-hot grant (all zero when idle), registered
//   t_pulse  out  1     one-cycle strobe: q toggled at the preceding edge
//   q        out  1     shared T flip-flop state
//   busy     out  1     1 while any gnt bit is set
//   tog_cnt  out  CW    number of toggles since reset/clr, wraps mod 2^CW
// BEHAVIOUR
//   Reset (rst=0, async, immediate): state=IDLE, gnt=0, t_pulse=0, q=0, busy=0,
//     tog_cnt=0, rr pointer ptr=0 ($clog2(NREQ) bits).
//   Priority at every edge: rst > clr > arbitration.
//   FSM states: IDLE, HOLD.
//   IDLE, req==0: nothing changes; t_pulse=0.
//   IDLE, req!=0:
//     winner w = first set bit scanning ptr, ptr+1, ... with mod-NREQ wrap.
//     Next edge: gnt=onehot(w), q=~q, t_pulse=1, tog_cnt+1,
//       ptr=(w+1) mod NREQ, hold_cnt=HOLD-1, state=HOLD.
//     Latency: req sampled at edge k; gnt/q/t_pulse valid after edge k.
//   HOLD:
//     t_pulse=0 after its single cycle.
//     If req[w]==0: next edge gnt=0, state=IDLE (early release).
//     Else if hold_cnt==0: next edge gnt=0, state=IDLE.
//     Else: hold_cnt decrements.
//     The early-release check has priority over the hold_cnt check.
//   Timing consequences:
//     gnt is high for exactly HOLD cycles unless released early.
//     At least one IDLE cycle with gnt=0 separates consecutive grants.
//     Other requests arriving during HOLD wait; no preemption.
//   clr=1 at an edge (any state):
//     q=0, tog_cnt=0, gnt=0, t_pulse=0, state=IDLE; ptr unchanged.
//     No grant is issued at that edge even if req!=0.
//   tog_cnt overflow: 2^CW-1 -> 0, no flag.
//   busy = |gnt (combinational from registered gnt).
//   req bits that change mid-cycle affect only the next edge; no combinational
//     req->gnt path.
// TESTING (NREQ=4, HOLD=2, CW=8)
//   1 Reset: rst=0 with req=1111 -> gnt=0000, q=0, t_pulse=0, tog_cnt=0, busy=0
//     held until rst=1.
//   2 Single requester: req=0100 held ->
//     edge1: gnt=0100, q=1, t_pulse=1, tog_cnt=1.
//     gnt high 2 cycles, then 1 cycle gnt=0000.
//     Next grant to the same requester: q=0, tog_cnt=2.
//   3 Fairness: req=1111 held -> grant order 0001,0010,0100,1000,0001;
//     each grant 2 cycles followed by 1 idle cycle; q alternates 1,0,1,0,1.
//   4 Early release: req=0010 granted, req dropped after 1 grant cycle ->
//     gnt=0000 next edge, q stays 1.
//     Then req=1010 -> next grant 1000 (ptr=2).
//   5 clr during HOLD with q=1, tog_cnt=3 -> next edge q=0, tog_cnt=0,
//     gnt=0000; following grant respects preserved ptr.
//   6 Async reset mid-HOLD (rst low between edges) -> gnt, q, tog_cnt
//     clear immediately.
//     256 grants from reset -> tog_cnt wraps to 0, q=0.

Source files
------------

// File: rtl/t_toggle_arbiter_if.sv
// Request/grant bundle between the requesters and the shared toggle arbiter.
// The master side issues requests and clear; the slave side is the arbiter.
interface t_toggle_arbiter_if #(
    parameter int NREQ = 4,
    parameter int CW   = 8
) ();
    logic            clr;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            t_pulse;
    logic            q;
    logic            busy;
    logic [CW-1:0]   tog_cnt;

    modport master (
        output clr, req,
        input  gnt, t_pulse, q, busy, tog_cnt
    );

    modport slave (
        input  clr, req,
        output gnt, t_pulse, q, busy, tog_cnt
    );
endinterface

// File: rtl/t_toggle_arbiter.sv
// Round-robin arbiter sharing one T flip-flop among NREQ requesters.
// Each grant toggles q exactly once, then holds ownership for HOLD cycles
// (or less if the owner drops its request). An idle cycle always separates
// two grants.
module t_toggle_arbiter #(
    parameter int NREQ = 4,
    parameter int HOLD = 2,
    parameter int CW   = 8
) (
    input logic               clk,
    input logic               rst,
    t_toggle_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            tpulse_q, tpulse_d;
    logic            tq_q, tq_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic [PW-1:0]   win;
    logic [PW-1:0]   idx;
    int              j;

    // Round-robin winner: scan downward so the lowest offset from ptr wins.
    always_comb begin
        win = '0;
        idx = '0;
        j   = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= NREQ) j = j - NREQ;
            idx = PW'(j);
            if (bus.req[idx]) win = idx;
        end
    end

    // Next-state logic: clear dominates, otherwise IDLE grants and HOLD counts down.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        tpulse_d = 1'b0;
        tq_d     = tq_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        hold_d   = hold_q;

        if (bus.clr) begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            tq_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        gnt_d      = '0;
                        gnt_d[win] = 1'b1;
                        tq_d       = ~tq_q;
                        tpulse_d   = 1'b1;
                        cnt_d      = cnt_q + CW'(1);
                        ptr_d      = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
                        hold_d     = HW'(HOLD - 1);
                        state_d    = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Owner dropping its request releases before the count expires.
                    if ((bus.req & gnt_q) == '0) begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end else if (hold_q == '0) begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        hold_d = hold_q - HW'(1);
                    end
                end
                default: begin
                    gnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            tpulse_q <= 1'b0;
            tq_q     <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            tpulse_q <= tpulse_d;
            tq_q     <= tq_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            hold_q   <= hold_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.t_pulse = tpulse_q;
    assign bus.q       = tq_q;
    assign bus.tog_cnt = cnt_q;
    assign bus.busy    = |gnt_q;
endmodule

// File: tb/tb_t_toggle_arbiter.sv
// Directed bench for t_toggle_arbiter (NREQ=4, HOLD=2, CW=8).
module tb_t_toggle_arbiter;
    logic clk;
    logic rst;
    int   tests_run;
    int   failed;

    t_toggle_arbiter_if #(.NREQ(4), .CW(8)) bus ();

    t_toggle_arbiter #(.NREQ(4), .HOLD(2), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        bus.req = 4'b0000;
        bus.clr = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst     = 1'b0;
        bus.clr = 1'b0;
        bus.req = 4'b1111;
        tick();
        tick();
        tick();
        tests_run++;
        if (bus.gnt !== 4'b0000) begin failed++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
        tests_run++;
        if (bus.q !== 1'b0) begin failed++; $display("FAIL reset_q: got %b want 0", bus.q); end
        tests_run++;
        if (bus.t_pulse !== 1'b0) begin failed++; $display("FAIL reset_tpulse: got %b want 0", bus.t_pulse); end
        tests_run++;
        if (bus.tog_cnt !== 8'd0) begin failed++; $display("FAIL reset_cnt: got %0d want 0", bus.tog_cnt); end
        tests_run++;
        if (bus.busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        bus.req = 4'b0000;
        rst     = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        bus.req = 4'b0100;
        tick();
        tests_run++;
        if (bus.gnt !== 4'b0100 || bus.q !== 1'b1 || bus.t_pulse !== 1'b1 || bus.tog_cnt !== 8'd1 || bus.busy !== 1'b1) begin
            failed++;
            $display("FAIL single_edge1: got gnt=%b q=%b tp=%b cnt=%0d busy=%b want 0100 1 1 1 1",
                     bus.gnt, bus.q, bus.t_pulse, bus.tog_cnt, bus.busy);
        end
        tick();
        tests_run++;
        if (bus.gnt !== 4'b0100 || bus.t_pulse !== 1'b0) begin
            failed++; $display("FAIL single_hold: got gnt=%b tp=%b want 0100 0", bus.gnt, bus.t_pulse);
        end
        tick();
        tests_run++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.q !== 1'b1) begin
            failed++; $display("FAIL single_idle: got gnt=%b busy=%b q=%b want 0000 0 1", bus.gnt, bus.busy, bus.q);
        end
        tick();
        tests_run++;
        if (bus.gnt !== 4'b0100 || bus.q !== 1'b0 || bus.t_pulse !== 1'b1 || bus.tog_cnt !== 8'd2) begin
            failed++;
            $display("FAIL single_regrant: got gnt=%b q=%b tp=%b cnt=%0d want 0100 0 1 2",
                     bus.gnt, bus.q, bus.t_pulse, bus.tog_cnt);
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_fairness();
        logic [3:0] exp_gnt;
        logic       exp_q;
        do_reset();
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            exp_gnt = 4'b0001 << (g % 4);
            exp_q   = (g % 2 == 0);
            tick();
            tests_run++;
            if (bus.gnt !== exp_gnt || bus.q !== exp_q || bus.t_pulse !== 1'b1 || bus.tog_cnt !== 8'(g + 1)) begin
                failed++;
                $display("FAIL fair_grant%0d: got gnt=%b q=%b tp=%b cnt=%0d want %b %b 1 %0d",
                         g, bus.gnt, bus.q, bus.t_pulse, bus.tog_cnt, exp_gnt, exp_q, g + 1);
            end
            tick();
            tests_run++;
            if (bus.gnt !== exp_gnt || bus.t_pulse !== 1'b0) begin
                failed++; $display("FAIL fair_hold%0d: got gnt=%b tp=%b want %b 0", g, bus.gnt, bus.t_pulse, exp_gnt);
            end
            tick();
            tests_run++;
            if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
                failed++; $display("FAIL fair_idle%0d: got gnt=%b busy=%b want 0000 0", g, bus.gnt, bus.busy);
            end
        end
        bus.req = 4'b0000;
    endtask

    task automatic test_early_release();
        do_reset();
        bus.req = 4'b0010;
        tick();
        tests_run++;
        if (bus.gnt !== 4'b0010 || bus.q !== 1'b1) begin
            failed++; $display("FAIL early_grant: got gnt=%b q=%b want 0010 1", bus.gnt, bus.q);
        end
        bus.req = 4'b0000;
        tick();
        tests_run++;
        if (bus.gnt !== 4'b0000 || bus.q !== 1'b1) begin
            failed++; $display("FAIL early_release: got gnt=%b q=%b want 0000 1", bus.gnt, bus.q);
        end
        bus.req = 4'b1010;
        tick();
        tests_run++;
        if (bus.gnt !== 4'b1000 || bus.q !== 1'b0 || bus.tog_cnt !== 8'd2) begin
            failed++; $display("FAIL early_next: got gnt=%b q=%b cnt=%0d want 1000 0 2", bus.gnt, bus.q, bus.tog_cnt);
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_clr();
        do_reset();
        bus.req = 4'b0001;
        for (int g = 0; g < 3; g++) begin
            tick();
            if (g < 2) begin
                tick();
                tick();
            end
        end
        tests_run++;
        if (bus.gnt !== 4'b0001 || bus.q !== 1'b1 || bus.tog_cnt !== 8'd3) begin
            failed++; $display("FAIL clr_setup: got gnt=%b q=%b cnt=%0d want 0001 1 3", bus.gnt, bus.q, bus.tog_cnt);
        end
        bus.clr = 1'b1;
        bus.req = 4'b1111;
        tick();
        tests_run++;
        if (bus.gnt !== 4'b0000 || bus.q !== 1'b0 || bus.tog_cnt !== 8'd0 || bus.t_pulse !== 1'b0) begin
            failed++;
            $display("FAIL clr_hold: got gnt=%b q=%b cnt=%0d tp=%b want 0000 0 0 0",
                     bus.gnt, bus.q, bus.tog_cnt, bus.t_pulse);
        end
        bus.clr = 1'b0;
        tick();
        tests_run++;
        if (bus.gnt !== 4'b0010 || bus.q !== 1'b1 || bus.tog_cnt !== 8'd1) begin
            failed++; $display("FAIL clr_ptr_kept: got gnt=%b q=%b cnt=%0d want 0010 1 1", bus.gnt, bus.q, bus.tog_cnt);
        end
        bus.req = 4'b0000;
        tick();
        bus.req = 4'b1111;
        bus.clr = 1'b1;
        tick();
        tests_run++;
        if (bus.gnt !== 4'b0000 || bus.q !== 1'b0 || bus.tog_cnt !== 8'd0 || bus.t_pulse !== 1'b0) begin
            failed++;
            $display("FAIL clr_idle_nogrant: got gnt=%b q=%b cnt=%0d tp=%b want 0000 0 0 0",
                     bus.gnt, bus.q, bus.tog_cnt, bus.t_pulse);
        end
        bus.clr = 1'b0;
        tick();
        tests_run++;
        if (bus.gnt !== 4'b0100 || bus.q !== 1'b1) begin
            failed++; $display("FAIL clr_idle_next: got gnt=%b q=%b want 0100 1", bus.gnt, bus.q);
        end
        bus.req = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.req = 4'b0001;
        tick();
        tests_run++;
        if (bus.gnt !== 4'b0001 || bus.q !== 1'b1 || bus.tog_cnt !== 8'd1) begin
            failed++; $display("FAIL async_setup: got gnt=%b q=%b cnt=%0d want 0001 1 1", bus.gnt, bus.q, bus.tog_cnt);
        end
        #2;
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.gnt !== 4'b0000 || bus.q !== 1'b0 || bus.tog_cnt !== 8'd0 || bus.busy !== 1'b0) begin
            failed++;
            $display("FAIL async_clear: got gnt=%b q=%b cnt=%0d busy=%b want 0000 0 0 0",
                     bus.gnt, bus.q, bus.tog_cnt, bus.busy);
        end
        bus.req = 4'b0000;
        #2;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        do_reset();
        bus.req = 4'b0001;
        for (int g = 0; g < 256; g++) begin
            tick();
            if (g == 254) begin
                tests_run++;
                if (bus.tog_cnt !== 8'hFF || bus.q !== 1'b1) begin
                    failed++; $display("FAIL wrap_255: got cnt=%0d q=%b want 255 1", bus.tog_cnt, bus.q);
                end
            end
            if (g == 255) begin
                tests_run++;
                if (bus.tog_cnt !== 8'd0 || bus.q !== 1'b0 || bus.gnt !== 4'b0001) begin
                    failed++;
                    $display("FAIL wrap_0: got cnt=%0d q=%b gnt=%b want 0 0 0001", bus.tog_cnt, bus.q, bus.gnt);
                end
            end
            tick();
            tick();
        end
        bus.req = 4'b0000;
    endtask

    initial begin
        tests_run = 0;
        failed    = 0;
        rst       = 1'b0;
        bus.req   = 4'b0000;
        bus.clr   = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_early_release();
        test_clr();
        test_async_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end
endmodule
